// File: rtl/fnd_decoder.sv
// Registered hex/BCD to 7-segment decoder for one common-cathode FND digit.
// Segment pattern is {a,b,c,d,e,f,g}; each led* output is driven by its own flop.
module fnd_decoder #(
    parameter bit HEX_EN     = 1'b1,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd,
    output logic       leda,
    output logic       ledb,
    output logic       ledc,
    output logic       ledd,
    output logic       lede,
    output logic       ledf,
    output logic       ledg
);

    localparam int unsigned SEG_W = 7;

    // Dark level at the pins, so reset and blanking agree with the polarity.
    localparam logic [SEG_W-1:0] SEG_DARK = ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};

    logic [SEG_W-1:0] seg_lit_c;
    logic [SEG_W-1:0] seg_pin_c;
    logic [SEG_W-1:0] seg_q;

    // Lit-segment pattern, 1 = lit, bit 6 = a ... bit 0 = g.
    always_comb begin
        seg_lit_c = '0;
        unique case (bcd)
            4'h0: seg_lit_c = 7'b111_1110;
            4'h1: seg_lit_c = 7'b011_0000;
            4'h2: seg_lit_c = 7'b110_1101;
            4'h3: seg_lit_c = 7'b111_1001;
            4'h4: seg_lit_c = 7'b011_0011;
            4'h5: seg_lit_c = 7'b101_1011;
            4'h6: seg_lit_c = 7'b101_1111;
            4'h7: seg_lit_c = 7'b111_0000;
            4'h8: seg_lit_c = 7'b111_1111;
            4'h9: seg_lit_c = 7'b111_1011;
            4'ha: seg_lit_c = HEX_EN ? 7'b111_0111 : 7'b000_0000;
            4'hb: seg_lit_c = HEX_EN ? 7'b001_1111 : 7'b000_0000;
            4'hc: seg_lit_c = HEX_EN ? 7'b100_1110 : 7'b000_0000;
            4'hd: seg_lit_c = HEX_EN ? 7'b011_1101 : 7'b000_0000;
            4'he: seg_lit_c = HEX_EN ? 7'b100_1111 : 7'b000_0000;
            4'hf: seg_lit_c = HEX_EN ? 7'b100_0111 : 7'b000_0000;
            default: seg_lit_c = '0;
        endcase
    end

    assign seg_pin_c = ACTIVE_LOW ? ~seg_lit_c : seg_lit_c;

    // Output register holds pin levels; reset wins over decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= SEG_DARK;
        end else begin
            seg_q <= seg_pin_c;
        end
    end

    assign {leda, ledb, ledc, ledd, lede, ledf, ledg} = seg_q;

endmodule

// File: tb/tb_fnd_decoder.sv
// Self-checking bench for fnd_decoder: default, HEX_EN=0 and ACTIVE_LOW=1 instances
// checked every cycle against a letter-set reference model plus directed literals.
module tb_fnd_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] bcd = 4'd0;

    logic a0, b0, c0, d0, e0, f0, g0;
    logic a1, b1, c1, d1, e1, f1, g1;
    logic a2, b2, c2, d2, e2, f2, g2;

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    fnd_decoder #(.HEX_EN(1'b1), .ACTIVE_LOW(1'b0)) dut_def (
        .clk(clk), .rst(rst), .bcd(bcd),
        .leda(a0), .ledb(b0), .ledc(c0), .ledd(d0), .lede(e0), .ledf(f0), .ledg(g0));

    fnd_decoder #(.HEX_EN(1'b0), .ACTIVE_LOW(1'b0)) dut_nohex (
        .clk(clk), .rst(rst), .bcd(bcd),
        .leda(a1), .ledb(b1), .ledc(c1), .ledd(d1), .lede(e1), .ledf(f1), .ledg(g1));

    fnd_decoder #(.HEX_EN(1'b1), .ACTIVE_LOW(1'b1)) dut_low (
        .clk(clk), .rst(rst), .bcd(bcd),
        .leda(a2), .ledb(b2), .ledc(c2), .ledd(d2), .lede(e2), .ledf(f2), .ledg(g2));

    logic [6:0] seg_def, seg_nohex, seg_low;
    assign seg_def   = {a0, b0, c0, d0, e0, f0, g0};
    assign seg_nohex = {a1, b1, c1, d1, e1, f1, g1};
    assign seg_low   = {a2, b2, c2, d2, e2, f2, g2};

    // Which segments are lit for each code, written as in the display table.
    function automatic string lit_letters(input int code);
        case (code)
            0:  return "abcdef";
            1:  return "bc";
            2:  return "abdeg";
            3:  return "abcdg";
            4:  return "bcfg";
            5:  return "acdfg";
            6:  return "acdefg";
            7:  return "abc";
            8:  return "abcdefg";
            9:  return "abcdfg";
            10: return "abcefg";
            11: return "cdefg";
            12: return "adef";
            13: return "bcdeg";
            14: return "adefg";
            default: return "aefg";
        endcase
    endfunction

    // Pin levels expected after an edge that sampled (reset, code).
    function automatic logic [6:0] model_seg(input int code, input bit hex_en,
                                             input bit active_low, input bit in_reset);
        string      s;
        logic [6:0] v;
        v = 7'd0;
        if (!in_reset && (hex_en || code < 10)) begin
            s = lit_letters(code);
            for (int k = 0; k < s.len(); k++) begin
                v[6 - (int'(s[k]) - int'("a"))] = 1'b1;
            end
        end
        return active_low ? ~v : v;
    endfunction

    task automatic check(input string name, input logic [6:0] actual, input logic [6:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference state: what each rising edge sampled.
    bit       exp_valid = 1'b0;
    bit       samp_rst  = 1'b0;
    int       samp_bcd  = 0;

    always @(posedge clk) begin
        if (rst) exp_valid <= 1'b1;
        samp_rst <= rst;
        samp_bcd <= int'(bcd);
    end

    // Continuous comparison, away from the active edge.
    always @(negedge clk) begin
        if (exp_valid) begin
            check("model_default", seg_def,   model_seg(samp_bcd, 1'b1, 1'b0, samp_rst));
            check("model_nohex",   seg_nohex, model_seg(samp_bcd, 1'b0, 1'b0, samp_rst));
            check("model_actlow",  seg_low,   model_seg(samp_bcd, 1'b1, 1'b1, samp_rst));
        end
    end

    initial begin
        // Reset with bcd=8 for two edges, then release.
        @(negedge clk);
        bcd = 4'd8;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_def_dark", seg_def, 7'b000_0000);
        check("reset_low_dark", seg_low, 7'b111_1111);
        rst = 1'b0;
        @(negedge clk);
        check("release_def_8", seg_def, 7'b111_1111);
        check("release_low_8", seg_low, 7'b000_0000);

        // Full sweep 0..15, bcd changing on falling edges.
        for (int i = 0; i < 16; i++) begin
            bcd = 4'(i);
            @(negedge clk);
            case (i)
                0:  begin
                        check("sweep_0", seg_def, 7'b111_1110);
                        check("actlow_0", seg_low, 7'b000_0001);
                    end
                1:  check("sweep_1", seg_def, 7'b011_0000);
                7:  check("sweep_7", seg_def, 7'b111_0000);
                9:  begin
                        check("sweep_9", seg_def, 7'b111_1011);
                        check("nohex_9", seg_nohex, 7'b111_1011);
                    end
                11: check("sweep_11", seg_def, 7'b001_1111);
                15: check("sweep_15", seg_def, 7'b100_0111);
                default: ;
            endcase
            if (i >= 10) check("nohex_blank", seg_nohex, 7'b000_0000);
        end

        // Latency: bcd changes just after a rising edge.
        bcd = 4'd3;
        @(posedge clk);
        #1 bcd = 4'd4;
        check("latency_hold_3", seg_def, 7'b111_1001);
        @(negedge clk);
        check("latency_fall_3", seg_def, 7'b111_1001);
        @(posedge clk);
        #1 check("latency_new_4", seg_def, 7'b011_0011);

        // Reset mid-sweep at bcd=5.
        @(negedge clk);
        bcd = 4'd5;
        rst = 1'b1;
        @(negedge clk);
        check("midreset_dark", seg_def, 7'b000_0000);
        rst = 1'b0;
        @(negedge clk);
        check("midreset_back_5", seg_def, 7'b101_1011);

        // Random stimulus with occasional resets; checked by the model process.
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            bcd = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 19) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
